// File: rtl/timer_share_sequencer.sv
// timer_share_sequencer
//
// Shares a single serial-command delay timer between N_REQ requesters.
// Requests are arbitrated round-robin. The winner's 4-bit delay code is sent
// to the timer as the start pattern 1101 followed by the delay bits, MSB first.
// The counting phase is supervised against a timeout, the timer's done is
// acknowledged, and a completion pulse goes back to the owning requester.
// A missing count start or a timeout parks the block in FAULT with a sticky
// err until reset.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   req             per-requester level request, held until its grant pulse
//   req_delay       delay codes, slice i = req_delay[4i+3:4i]
//   grant           one-hot 1-cycle pulse, coincides with the first serial bit
//   cmp             one-hot 1-cycle completion pulse to the owner
//   busy            high in every state except IDLE
//   owner           index of the current owner (valid while busy)
//   err             sticky timeout / no-start flag
//   timer_data      serial command line to the timer
//   timer_ack       1-cycle acknowledge of timer_done
//   timer_counting  timer is counting
//   timer_done      timer has finished counting

module timer_share_sequencer #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 17000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] req_delay,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   cmp,
    output logic               busy,
    output logic [2:0]         owner,
    output logic               err,
    output logic               timer_data,
    output logic               timer_ack,
    input  logic               timer_counting,
    input  logic               timer_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_CNT,
        RUN,
        ACK,
        GAP,
        FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic             wait_cnt, wait_cnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic [N_REQ-1:0] grant_nxt, cmp_nxt;
    logic             busy_nxt, err_nxt, ack_nxt;
    logic [2:0]       owner_nxt;

    logic [7:0]       req_pad;
    logic [3:0]       cand;
    logic             win_valid;
    logic [2:0]       win_idx;
    logic [N_REQ-1:0] win_hot;
    logic [3:0]       win_delay;
    logic [N_REQ-1:0] owner_hot;
    logic [2:0]       owner_inc;

    // The serial line is the MSB of the shift register; the register is zero
    // outside SEND, which keeps the line low in every other state.
    assign timer_data = shreg[7];

    // Round-robin scan starting at the pointer. The candidate index wraps at
    // N_REQ explicitly because N_REQ need not be a power of two.
    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = req;
        cand                 = '0;
        win_valid            = 1'b0;
        win_idx              = '0;
        win_hot              = '0;
        win_delay            = '0;
        owner_hot            = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!win_valid && req_pad[cand[2:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[2:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            win_hot[i]   = (win_idx == 3'(i));
            owner_hot[i] = (owner == 3'(i));
            if (win_idx == 3'(i)) begin
                win_delay = req_delay[4*i +: 4];
            end
        end
        owner_inc = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_valid && !err) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bit_cnt == 3'd7) begin
                    state_nxt = WAIT_CNT;
                end
            end
            WAIT_CNT: begin
                if (timer_counting) begin
                    state_nxt = RUN;
                end else if (wait_cnt) begin
                    state_nxt = FAULT;
                end
            end
            RUN: begin
                if (timer_done) begin
                    state_nxt = ACK;
                end else if (tcnt == TLAST) begin
                    state_nxt = FAULT;
                end
            end
            ACK:     state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath. Pulse outputs are
    // computed from the state being entered so that they are high during
    // that state.
    always_comb begin
        grant_nxt    = '0;
        cmp_nxt      = '0;
        ack_nxt      = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        err_nxt      = err | (state_nxt == FAULT);
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        shreg_nxt    = '0;
        bit_cnt_nxt  = '0;
        wait_cnt_nxt = 1'b0;
        tcnt_nxt     = tcnt;
        case (state)
            IDLE: begin
                if (state_nxt == SEND) begin
                    grant_nxt = win_hot;
                    owner_nxt = win_idx;
                    shreg_nxt = {4'b1101, win_delay};
                end
            end
            SEND: begin
                shreg_nxt   = {shreg[6:0], 1'b0};
                bit_cnt_nxt = bit_cnt + 3'd1;
            end
            WAIT_CNT: begin
                wait_cnt_nxt = 1'b1;
                tcnt_nxt     = '0;
            end
            RUN: begin
                if (tcnt != TLAST) begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ACK: begin
                ptr_nxt = owner_inc;
            end
            default: ;
        endcase
        if (state_nxt == ACK) begin
            ack_nxt = 1'b1;
            cmp_nxt = owner_hot;
        end
        // A faulted owner is passed over, as after a normal completion.
        if (state_nxt == FAULT && state != FAULT) begin
            ptr_nxt = owner_inc;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= 1'b0;
            tcnt      <= '0;
            grant     <= '0;
            cmp       <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            err       <= 1'b0;
            timer_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            tcnt      <= tcnt_nxt;
            grant     <= grant_nxt;
            cmp       <= cmp_nxt;
            busy      <= busy_nxt;
            owner     <= owner_nxt;
            err       <= err_nxt;
            timer_ack <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_timer_share_sequencer.sv
// Testbench for timer_share_sequencer.
// A behavioural timer decodes the serial stream and counts (d+1)*UNIT cycles
// (UNIT scaled down from 1000 to keep runs short). A transaction-level model
// predicts the round-robin winner, the serial bits, the completion pulse and
// the pointer advance; fault cases use a timer that hangs or never starts.

module tb_timer_share_sequencer;

    localparam int N          = 4;
    localparam int TB_TIMEOUT = 150;
    localparam int UNIT       = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [4*N-1:0] req_delay;
    logic [N-1:0]   grant;
    logic [N-1:0]   cmp;
    logic           busy;
    logic [2:0]     owner;
    logic           err;
    logic           timer_data;
    logic           timer_ack;
    logic           timer_counting;
    logic           timer_done;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ptr_model = 0;
    logic [3:0] delays [N];

    bit         timer_hang = 1'b0;
    bit         timer_nostart = 1'b0;
    int         tphase;
    int         tm_cnt;
    logic [7:0] hist;

    timer_share_sequencer #(
        .N_REQ   (N),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_delay      (req_delay),
        .grant          (grant),
        .cmp            (cmp),
        .busy           (busy),
        .owner          (owner),
        .err            (err),
        .timer_data     (timer_data),
        .timer_ack      (timer_ack),
        .timer_counting (timer_counting),
        .timer_done     (timer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural timer: watches for 1101dddd, counts, raises done until acked.
    initial begin
        timer_counting = 1'b0;
        timer_done     = 1'b0;
        hist           = '0;
        tphase         = 0;
        tm_cnt         = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hist           = '0;
                tphase         = 0;
                timer_counting = 1'b0;
                timer_done     = 1'b0;
            end else begin
                case (tphase)
                    0: begin
                        hist = {hist[6:0], timer_data};
                        if (hist[7:4] == 4'b1101 && !timer_nostart) begin
                            tm_cnt         = (int'(hist[3:0]) + 1) * UNIT;
                            timer_counting = 1'b1;
                            tphase         = 1;
                            hist           = '0;
                        end
                    end
                    1: begin
                        if (!timer_hang) begin
                            tm_cnt = tm_cnt - 1;
                            if (tm_cnt == 0) begin
                                timer_counting = 1'b0;
                                timer_done     = 1'b1;
                                tphase         = 2;
                            end
                        end
                    end
                    default: begin
                        if (timer_ack) begin
                            timer_done = 1'b0;
                            tphase     = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [3:0] d);
        delays[idx]           = d;
        req_delay[4*idx +: 4] = d;
        req[idx]              = 1'b1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset_outputs", {grant, cmp, busy, owner, err, timer_data, timer_ack}, 32'd0);
        reset     = 1'b0;
        ptr_model = 0;
    endtask

    // One full grant..completion transaction, called with the DUT idle and
    // the request vector settled at the preceding negedge.
    task automatic run_transaction(input bit may_keep, input bit may_add);
        int         w;
        int         waited;
        int         gcyc;
        int         r;
        int         lat;
        int         idx;
        logic [3:0] d;
        logic [8:0] bits;
        logic [N-1:0] exp_g;
        bit         owner_ok;
        bit         stray;
        bit         got;

        w = rr_pick(req, ptr_model);
        if (w < 0) begin
            check_output("pending_nonzero", 32'd0, 32'd1);
            return;
        end
        exp_g    = '0;
        exp_g[w] = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (grant == '0 && waited < 20);
        check_output("grant_latency", waited, 32'd1);
        if (grant == '0) return;
        check_output("grant_vec", grant, exp_g);
        check_output("owner_at_grant", owner, 3'(w));
        check_output("busy_at_grant", busy, 1'b1);
        gcyc    = cyc;
        d       = delays[w];
        bits[8] = timer_data;
        if (may_keep && $urandom_range(0, 2) == 0) begin
            delays[w]           = 4'($urandom_range(0, 15));
            req_delay[4*w +: 4] = delays[w];
        end else begin
            req[w] = 1'b0;
        end
        owner_ok = 1'b1;
        stray    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bits[i] = timer_data;
            if (owner !== 3'(w) || busy !== 1'b1) owner_ok = 1'b0;
        end
        check_output("serial_bits", bits, {4'b1101, d, 1'b0});

        r   = (int'(d) + 1) * UNIT;
        got = 1'b0;
        for (int k = 0; k < r + 40; k++) begin
            @(negedge clk);
            if (cmp != '0) begin
                got = 1'b1;
                break;
            end
            if (owner !== 3'(w) || busy !== 1'b1) owner_ok = 1'b0;
            if (grant != '0 || timer_ack != 1'b0 || err != 1'b0) stray = 1'b1;
            if (may_add && $urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, N - 1);
                if (!req[idx]) apply_stimulus(idx, 4'($urandom_range(0, 15)));
            end
        end
        check_output("cmp_seen", got, 1'b1);
        if (!got) return;
        lat = cyc - gcyc;
        check_output("cmp_vec", cmp, exp_g);
        check_output("ack_with_cmp", timer_ack, 1'b1);
        check_output("owner_during_busy", owner_ok, 1'b1);
        check_output("no_stray_pulses", stray, 1'b0);
        // The bench timer starts counting on the 8th serial bit, so its run
        // overlaps the tail of the command; allow a small window.
        check_output("latency_window", (lat >= r + 6 && lat <= r + 12), 1'b1);
        ptr_model = (w + 1) % N;
        @(negedge clk);
        check_output("gap_outputs", {busy, cmp, timer_ack, timer_data}, 7'b1000000);
        @(negedge clk);
        check_output("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int         guard;
        int         gcyc;
        int         n;
        bit         got;
        bit         stray;

        reset     = 1'b1;
        req       = '0;
        req_delay = '0;
        for (int i = 0; i < N; i++) delays[i] = '0;
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {grant, cmp, busy, owner, err, timer_data, timer_ack}, 32'd0);
        reset = 1'b0;

        // All four requesting, delays 1..4: served 0,1,2,3.
        for (int i = 0; i < N; i++) apply_stimulus(i, 4'(i + 1));
        for (int i = 0; i < N; i++) run_transaction(1'b0, 1'b0);

        // Single requester 0 with delay 0.
        apply_stimulus(0, 4'd0);
        run_transaction(1'b0, 1'b0);

        // Serve 1 (pointer moves to 2), then 0 and 1 together: 0 first.
        apply_stimulus(1, 4'd2);
        run_transaction(1'b0, 1'b0);
        apply_stimulus(0, 4'd1);
        apply_stimulus(1, 4'd0);
        run_transaction(1'b0, 1'b0);
        run_transaction(1'b0, 1'b0);

        // Randomised traffic.
        for (int t = 0; t < 14; t++) begin
            if (req == '0) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) apply_stimulus($urandom_range(0, N - 1), 4'($urandom_range(0, 15)));
            end
            run_transaction(1'b1, 1'b1);
        end
        guard = 0;
        while (req != '0 && guard < 20) begin
            run_transaction(1'b0, 1'b0);
            guard++;
        end

        // Requester 2 with delay 1010.
        apply_stimulus(2, 4'b1010);
        run_transaction(1'b0, 1'b0);

        // Reset during SEND bit 5 (pointer is 3 beforehand).
        apply_stimulus(3, 4'b1011);
        @(negedge clk);
        check_output("grant_before_reset", grant, 4'b1000);
        repeat (4) @(negedge clk);
        check_output("send_bit5", timer_data, 1'b1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check_output("reset_mid_send", {grant, cmp, busy, owner, err, timer_data, timer_ack}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        ptr_model = 0;
        apply_stimulus(3, 4'd1);
        apply_stimulus(1, 4'd2);
        run_transaction(1'b0, 1'b0);
        run_transaction(1'b0, 1'b0);

        // Timer that never finishes: timeout fault.
        timer_hang = 1'b1;
        apply_stimulus(0, 4'd3);
        @(negedge clk);
        check_output("grant_hang", grant, 4'b0001);
        gcyc   = cyc;
        req[0] = 1'b0;
        got    = 1'b0;
        stray  = 1'b0;
        for (int k = 0; k < TB_TIMEOUT + 40; k++) begin
            @(negedge clk);
            if (err) begin
                got = 1'b1;
                break;
            end
            if (cmp != '0 || timer_ack != 1'b0) stray = 1'b1;
        end
        check_output("err_seen", got, 1'b1);
        check_output("timeout_latency", cyc - gcyc, TB_TIMEOUT + 9);
        check_output("no_cmp_on_timeout", stray, 1'b0);
        check_output("fault_outputs", {busy, timer_data, timer_ack, cmp, grant}, 11'b10000000000);
        apply_stimulus(1, 4'd1);
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (grant != '0 || cmp != '0) stray = 1'b1;
        end
        check_output("no_grant_in_fault", stray, 1'b0);
        check_output("err_sticky", err, 1'b1);
        timer_hang = 1'b0;
        do_reset();

        // Timer that never starts counting: fault after two waiting cycles.
        timer_nostart = 1'b1;
        apply_stimulus(2, 4'd5);
        @(negedge clk);
        check_output("grant_nostart", grant, 4'b0100);
        gcyc   = cyc;
        req[2] = 1'b0;
        got    = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (err) begin
                got = 1'b1;
                break;
            end
        end
        check_output("err_nostart", got, 1'b1);
        check_output("nostart_latency", cyc - gcyc, 32'd10);
        check_output("nostart_outputs", {busy, cmp, timer_ack, timer_data}, 7'b1000000);
        timer_nostart = 1'b0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
